// File: rtl/block_frame_scanout_if.sv
// RAM-read and bank-swap bus between block_frame_scanout (master) and the
// frame writer / block RAM side (slave).
interface block_frame_scanout_if #(
    parameter int ADDR_W = 12
) ();
    // swap_req is a level that the writer holds until it sees swap_ack.
    // swap_ack is a one-cycle pulse on the cycle the display bank flips.
    // The writer drops swap_req after that edge. rd_addr is presented every
    // cycle, and rd_data answers it one cycle later.
    logic              swap_req;
    logic              swap_ack;
    logic              whichRAM;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    modport master (
        input  swap_req,
        input  rd_data,
        output swap_ack,
        output whichRAM,
        output rd_addr
    );

    modport slave (
        output swap_req,
        output rd_data,
        input  swap_ack,
        input  whichRAM,
        input  rd_addr
    );
endinterface

// File: rtl/block_frame_scanout.sv
// VGA scanout of a double-buffered 40x30 block frame buffer, with a bank swap at frame end.
// Optional SCANOUT_GRID_EN: grey overlay on the block boundaries.
module block_frame_scanout #(
    parameter int BLOCK_SHIFT = 4,
    parameter int ADDR_W      = 12,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    block_frame_scanout_if.master  bus,
    output logic                   frame_start,
    output logic                   VGA_HS,
    output logic                   VGA_VS,
    output logic                   VGA_BLANK_N,
    output logic [7:0]             VGA_R,
    output logic [7:0]             VGA_G,
    output logic [7:0]             VGA_B
);
    localparam int CNT_W   = 10;
    localparam int IDX_W   = ADDR_W - 1;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BX_LAST = (H_ACTIVE - 1) >> BLOCK_SHIFT;
    localparam int BY_LAST = (V_ACTIVE - 1) >> BLOCK_SHIFT;

    // S0: counters, bank and address
    logic [CNT_W-1:0] hc, vc;
    logic             dispBank, whichRam, frameStartQ;
    logic             lastCol, lastLine, frameEnd, swapTake;
    logic             hActive, vActive, active, hsN, vsN;
    logic [IDX_W-1:0] bx, by, blockIdx;

    always_comb begin
        lastCol  = (hc == CNT_W'(H_TOTAL - 1));
        lastLine = (vc == CNT_W'(V_TOTAL - 1));
        frameEnd = lastCol && lastLine;
        swapTake = frameEnd && bus.swap_req;
        hActive  = (hc < CNT_W'(H_ACTIVE));
        vActive  = (vc < CNT_W'(V_ACTIVE));
        active   = hActive && vActive;
        hsN      = !((hc >= CNT_W'(H_ACTIVE + H_FP)) && (hc < CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
        vsN      = !((vc >= CNT_W'(V_ACTIVE + V_FP)) && (vc < CNT_W'(V_ACTIVE + V_FP + V_SYNC)));
        // Blanking keeps the address parked on the last block of the grid row/column.
        bx       = hActive ? IDX_W'(hc >> BLOCK_SHIFT) : IDX_W'(BX_LAST);
        by       = vActive ? IDX_W'(vc >> BLOCK_SHIFT) : IDX_W'(BY_LAST);
        blockIdx = (by << 5) + (by << 3) + bx;
    end

    assign bus.rd_addr  = {dispBank, blockIdx};
    assign bus.swap_ack = swapTake;
    assign bus.whichRAM = whichRam;
    assign frame_start  = frameStartQ;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hc          <= '0;
            vc          <= '0;
            dispBank    <= 1'b0;
            whichRam    <= 1'b1;
            frameStartQ <= 1'b0;
        end else begin
            if (lastCol) begin
                hc <= '0;
                vc <= lastLine ? '0 : vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end
            // Pulses while the counters sit at (0,0), i.e. the cycle after frame end.
            frameStartQ <= frameEnd;
            if (swapTake) begin
                dispBank <= ~dispBank;
                whichRam <= dispBank;
            end
        end
    end

    // S1: flags travel alongside the RAM read
    logic s1Active, s1Hs, s1Vs;
`ifdef SCANOUT_GRID_EN
    logic s1GridH, s1GridV;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1Active <= 1'b0;
            s1Hs     <= 1'b1;
            s1Vs     <= 1'b1;
`ifdef SCANOUT_GRID_EN
            s1GridH  <= 1'b0;
            s1GridV  <= 1'b0;
`endif
        end else begin
            s1Active <= active;
            s1Hs     <= hsN;
            s1Vs     <= vsN;
`ifdef SCANOUT_GRID_EN
            s1GridH  <= (hc[BLOCK_SHIFT-1:0] == '0);
            s1GridV  <= (vc[BLOCK_SHIFT-1:0] == '0);
`endif
        end
    end

    // Unpack 3:3:2 by bit replication so that full-scale codes reach 8'hFF.
    logic [2:0] r3, g3;
    logic [1:0] b2;
    logic [7:0] pixR, pixG, pixB;

    assign r3 = bus.rd_data[2:0];
    assign g3 = bus.rd_data[5:3];
    assign b2 = bus.rd_data[7:6];

    always_comb begin
        pixR = {r3, r3, r3[2:1]};
        pixG = {g3, g3, g3[2:1]};
        pixB = {b2, b2, b2, b2};
        if (!s1Active) begin
            pixR = '0;
            pixG = '0;
            pixB = '0;
        end
`ifdef SCANOUT_GRID_EN
        else if (s1GridH || s1GridV) begin
            pixR = 8'h80;
            pixG = 8'h80;
            pixB = 8'h80;
        end
`endif
    end

    // S2: registered outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else begin
            VGA_HS      <= s1Hs;
            VGA_VS      <= s1Vs;
            VGA_BLANK_N <= s1Active;
            VGA_R       <= pixR;
            VGA_G       <= pixG;
            VGA_B       <= pixB;
        end
    end
endmodule

// File: tb/tb_block_frame_scanout.sv
// Bench for block_frame_scanout: a full 640x480 instance for line timing, and a
// reduced-geometry instance (64x112 total, 48x104 active) for frame, swap, address and reset scenarios.
module tb_block_frame_scanout;
    logic clk = 1'b0;
    logic rstF_n, rstS_n;
    logic ramPatternS;
    int   testsRun, testsFailed;
    int   pos, lastFs;

    logic       fFs, fHs, fVs, fBlank;
    logic [7:0] fR, fG, fB;
    logic       sFs, sHs, sVs, sBlank;
    logic [7:0] sR, sG, sB;

    block_frame_scanout_if #(.ADDR_W(12)) busF ();
    block_frame_scanout_if #(.ADDR_W(12)) busS ();

    always #20 clk = ~clk;

    block_frame_scanout dutFull (
        .Clk(clk), .Reset_n(rstF_n), .bus(busF), .frame_start(fFs),
        .VGA_HS(fHs), .VGA_VS(fVs), .VGA_BLANK_N(fBlank), .VGA_R(fR), .VGA_G(fG), .VGA_B(fB)
    );

    block_frame_scanout #(
        .H_ACTIVE(48), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(104), .V_FP(2), .V_SYNC(2), .V_BP(4)
    ) dutSmall (
        .Clk(clk), .Reset_n(rstS_n), .bus(busS), .frame_start(sFs),
        .VGA_HS(sHs), .VGA_VS(sVs), .VGA_BLANK_N(sBlank), .VGA_R(sR), .VGA_G(sG), .VGA_B(sB)
    );

    // Block RAM models: one-cycle read latency; constant colour per bank, or the index low byte.
    always_ff @(posedge clk) busF.rd_data <= busF.rd_addr[11] ? 8'h38 : 8'h07;
    always_ff @(posedge clk)
        busS.rd_data <= ramPatternS ? busS.rd_addr[7:0] : (busS.rd_addr[11] ? 8'h38 : 8'h07);

    function automatic logic [23:0] exp_rgb(int h, int v, logic [7:0] p, int hAct, int vAct);
        if (!(h < hAct && v < vAct)) return 24'h0;
`ifdef SCANOUT_GRID_EN
        if ((h % 16 == 0) || (v % 16 == 0)) return 24'h808080;
`endif
        return {p[2:0], p[2:0], p[2:1], p[5:3], p[5:3], p[5:4], p[7:6], p[7:6], p[7:6], p[7:6]};
    endfunction

    task automatic step();
        @(negedge clk);
        pos++;
    endtask

    task automatic step_to(int target);
        while (pos < target) step();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        testsRun++; if (sHs !== 1'b1) begin testsFailed++; $display("FAIL reset_hs: got %b expected 1", sHs); end
        testsRun++; if (sVs !== 1'b1) begin testsFailed++; $display("FAIL reset_vs: got %b expected 1", sVs); end
        testsRun++; if (sBlank !== 1'b0) begin testsFailed++; $display("FAIL reset_blank: got %b expected 0", sBlank); end
        testsRun++; if ({sR, sG, sB} !== 24'h0) begin testsFailed++; $display("FAIL reset_rgb: got %h expected 000000", {sR, sG, sB}); end
        testsRun++; if (busS.whichRAM !== 1'b1) begin testsFailed++; $display("FAIL reset_whichram: got %b expected 1", busS.whichRAM); end
        testsRun++; if (busS.swap_ack !== 1'b0) begin testsFailed++; $display("FAIL reset_ack: got %b expected 0", busS.swap_ack); end
        testsRun++; if (sFs !== 1'b0) begin testsFailed++; $display("FAIL reset_frame_start: got %b expected 0", sFs); end
        testsRun++; if (busS.rd_addr !== 12'h000) begin testsFailed++; $display("FAIL reset_rd_addr: got %h expected 000", busS.rd_addr); end
        testsRun++; if (fBlank !== 1'b0) begin testsFailed++; $display("FAIL reset_full_blank: got %b expected 0", fBlank); end
    endtask

    task automatic test_line_timing();
        int fall0, fall1, hsLow, vsLow, blankCnt, firstBlank, colErr, addrErr, fsCnt, ackCnt, wErr, h, v;
        logic prevHs;
        logic [23:0] expC;
        fall0 = -1; fall1 = -1; hsLow = 0; vsLow = 0; blankCnt = 0; firstBlank = -1;
        colErr = 0; addrErr = 0; fsCnt = 0; ackCnt = 0; wErr = 0; prevHs = 1'b1;
        rstF_n = 1'b1;
        for (int p = 0; p < 1602; p++) begin
            if (p > 0) @(negedge clk);
            if (!fHs && prevHs) begin
                if (fall0 < 0) fall0 = p;
                else if (fall1 < 0) fall1 = p;
            end
            prevHs = fHs;
            if (!fHs) hsLow++;
            if (!fVs) vsLow++;
            if (fFs) fsCnt++;
            if (busF.swap_ack) ackCnt++;
            if (busF.whichRAM !== 1'b1) wErr++;
            if (busF.rd_addr[11] !== 1'b0) addrErr++;
            if (fBlank) begin
                blankCnt++;
                if (firstBlank < 0) firstBlank = p;
            end
            if (p >= 2) begin
                h = (p - 2) % 800;
                v = (p - 2) / 800;
                expC = exp_rgb(h, v, 8'h07, 640, 480);
                if ({fR, fG, fB} !== expC || fBlank !== ((h < 640) && (v < 480))) colErr++;
            end
        end
        testsRun++; if (fall0 !== 658) begin testsFailed++; $display("FAIL hs_first_fall: got %0d expected 658", fall0); end
        testsRun++; if (fall1 - fall0 !== 800) begin testsFailed++; $display("FAIL hs_period: got %0d expected 800", fall1 - fall0); end
        testsRun++; if (hsLow !== 192) begin testsFailed++; $display("FAIL hs_low_cycles: got %0d expected 192", hsLow); end
        testsRun++; if (vsLow !== 0) begin testsFailed++; $display("FAIL vs_idle_lines01: got %0d expected 0", vsLow); end
        testsRun++; if (firstBlank !== 2) begin testsFailed++; $display("FAIL blank_first: got %0d expected 2", firstBlank); end
        testsRun++; if (blankCnt !== 1280) begin testsFailed++; $display("FAIL blank_count: got %0d expected 1280", blankCnt); end
        testsRun++; if (colErr !== 0) begin testsFailed++; $display("FAIL full_bank0_colour: got %0d bad pixels expected 0", colErr); end
        testsRun++; if (addrErr !== 0) begin testsFailed++; $display("FAIL full_bank_bit: got %0d bank1 reads expected 0", addrErr); end
        testsRun++; if (fsCnt + ackCnt + wErr !== 0) begin testsFailed++; $display("FAIL full_idle_ctrl: got %0d events expected 0", fsCnt + ackCnt + wErr); end
    endtask

    task automatic test_frame();
        int fsCnt, fsPos, vsFall, vsLow, blankCnt, colErr, addrErr, ackCnt, wErr, h, v;
        logic prevVs;
        fsCnt = 0; fsPos = -1; vsFall = -1; vsLow = 0; blankCnt = 0; colErr = 0;
        addrErr = 0; ackCnt = 0; wErr = 0; prevVs = 1'b1;
        rstS_n = 1'b1;
        pos = 0;
        for (int k = 0; k < 7170; k++) begin
            if (k > 0) step();
            if (sFs) begin fsCnt++; fsPos = pos; end
            if (!sVs && prevVs && vsFall < 0) vsFall = pos;
            prevVs = sVs;
            if (!sVs) vsLow++;
            if (sBlank) blankCnt++;
            if (busS.swap_ack) ackCnt++;
            if (busS.whichRAM !== 1'b1) wErr++;
            if (busS.rd_addr[11] !== 1'b0) addrErr++;
            if (pos >= 2) begin
                h = (pos - 2) % 64;
                v = (pos - 2) / 64;
                if ({sR, sG, sB} !== exp_rgb(h, v, 8'h07, 48, 104) || sBlank !== ((h < 48) && (v < 104))) colErr++;
            end
        end
        lastFs = fsPos;
        testsRun++; if (fsCnt !== 1 || fsPos !== 7168) begin testsFailed++; $display("FAIL frame_start_first: got %0d pulses at %0d expected 1 at 7168", fsCnt, fsPos); end
        testsRun++; if (vsFall !== 6786) begin testsFailed++; $display("FAIL vs_fall: got %0d expected 6786", vsFall); end
        testsRun++; if (vsLow !== 128) begin testsFailed++; $display("FAIL vs_two_lines: got %0d expected 128", vsLow); end
        testsRun++; if (blankCnt !== 4992) begin testsFailed++; $display("FAIL blank_frame: got %0d expected 4992", blankCnt); end
        testsRun++; if (colErr !== 0) begin testsFailed++; $display("FAIL bank0_colour: got %0d bad pixels expected 0", colErr); end
        testsRun++; if (addrErr !== 0) begin testsFailed++; $display("FAIL bank0_addr: got %0d bank1 reads expected 0", addrErr); end
        testsRun++; if (ackCnt + wErr !== 0) begin testsFailed++; $display("FAIL no_swap_hold: got %0d events expected 0", ackCnt + wErr); end
    endtask

    task automatic test_swap_mid();
        int ackPos, fsBetween, fsGap;
        logic wAtAck;
        ackPos = -1; fsBetween = 0; wAtAck = 1'bx;
        step_to(7200);
        busS.swap_req = 1'b1;
        while (ackPos < 0 && pos < 16000) begin
            step();
            if (sFs) fsBetween++;
            if (busS.swap_ack) begin ackPos = pos; wAtAck = busS.whichRAM; end
        end
        testsRun++; if (ackPos !== 14335) begin testsFailed++; $display("FAIL swap_ack_pos: got %0d expected 14335", ackPos); end
        testsRun++; if (wAtAck !== 1'b1) begin testsFailed++; $display("FAIL whichram_before_edge: got %b expected 1", wAtAck); end
        testsRun++; if (fsBetween !== 0) begin testsFailed++; $display("FAIL frame_start_spurious: got %0d expected 0", fsBetween); end
        step();
        busS.swap_req = 1'b0;
        fsGap = sFs ? pos - lastFs : -1;
        testsRun++; if (busS.whichRAM !== 1'b0) begin testsFailed++; $display("FAIL whichram_after_swap: got %b expected 0", busS.whichRAM); end
        testsRun++; if (busS.rd_addr[11] !== 1'b1) begin testsFailed++; $display("FAIL bank1_read: got %b expected 1", busS.rd_addr[11]); end
        testsRun++; if (fsGap !== 7168) begin testsFailed++; $display("FAIL frame_start_period: got %0d expected 7168", fsGap); end
        step_to(14535);
        testsRun++; if ({sR, sG, sB} !== 24'h00FF00 || sBlank !== 1'b1) begin testsFailed++; $display("FAIL bank1_colour: got %h blank %b expected 00ff00 blank 1", {sR, sG, sB}, sBlank); end
    endtask

    task automatic test_swap_exact();
        step_to(21503);
        testsRun++; if (busS.swap_ack !== 1'b0) begin testsFailed++; $display("FAIL ack_without_req: got %b expected 0", busS.swap_ack); end
        busS.swap_req = 1'b1;
        #1;
        testsRun++; if (busS.swap_ack !== 1'b1) begin testsFailed++; $display("FAIL ack_exact_cycle: got %b expected 1", busS.swap_ack); end
        step();
        busS.swap_req = 1'b0;
        testsRun++; if (busS.whichRAM !== 1'b1 || busS.rd_addr[11] !== 1'b0) begin testsFailed++; $display("FAIL exact_swap_bank: got whichRAM %b bank %b expected 1 0", busS.whichRAM, busS.rd_addr[11]); end
    endtask

    task automatic test_back_to_back();
        int ackCnt, firstAck;
        logic midBank;
        ackCnt = 0; firstAck = -1; midBank = 1'bx;
        step();
        busS.swap_req = 1'b1;
        while (pos < 35840) begin
            step();
            if (busS.swap_ack) begin
                ackCnt++;
                if (firstAck < 0) firstAck = pos;
            end
            if (pos == 28672) midBank = busS.rd_addr[11];
        end
        busS.swap_req = 1'b0;
        testsRun++; if (ackCnt !== 2) begin testsFailed++; $display("FAIL held_req_ack_count: got %0d expected 2", ackCnt); end
        testsRun++; if (firstAck !== 28671) begin testsFailed++; $display("FAIL held_req_first_ack: got %0d expected 28671", firstAck); end
        testsRun++; if (midBank !== 1'b1) begin testsFailed++; $display("FAIL held_req_mid_bank: got %b expected 1", midBank); end
        testsRun++; if (busS.whichRAM !== 1'b1) begin testsFailed++; $display("FAIL held_req_final_whichram: got %b expected 1", busS.whichRAM); end
    endtask

    task automatic test_address();
        ramPatternS = 1'b1;
        step_to(37137);
        testsRun++; if ({sR, sG, sB} !== 24'h00B600) begin testsFailed++; $display("FAIL pix_15_20: got %h expected 00b600", {sR, sG, sB}); end
        step_to(37139);
        testsRun++; if ({sR, sG, sB} !== 24'h24B600) begin testsFailed++; $display("FAIL pix_17_20: got %h expected 24b600", {sR, sG, sB}); end
        step_to(37155);
        testsRun++; if (busS.rd_addr !== 12'd42) begin testsFailed++; $display("FAIL addr_35_20: got %0d expected 42", busS.rd_addr); end
        step_to(37157);
        testsRun++; if ({sR, sG, sB} !== 24'h49B600 || sBlank !== 1'b1) begin testsFailed++; $display("FAIL pix_35_20: got %h blank %b expected 49b600 blank 1", {sR, sG, sB}, sBlank); end
    endtask

    task automatic test_reset_mid();
        logic [23:0] expGrid;
`ifdef SCANOUT_GRID_EN
        expGrid = 24'h808080;
`else
        expGrid = 24'h240000;
`endif
        step_to(42260);
        testsRun++; if (sBlank !== 1'b1) begin testsFailed++; $display("FAIL pre_reset_blank: got %b expected 1", sBlank); end
        rstS_n = 1'b0;
        #1;
        testsRun++; if (sBlank !== 1'b0 || {sR, sG, sB} !== 24'h0) begin testsFailed++; $display("FAIL async_reset_pixels: got blank %b rgb %h expected 0 000000", sBlank, {sR, sG, sB}); end
        testsRun++; if (sHs !== 1'b1 || sVs !== 1'b1) begin testsFailed++; $display("FAIL async_reset_syncs: got %b%b expected 11", sHs, sVs); end
        testsRun++; if (busS.rd_addr !== 12'h000) begin testsFailed++; $display("FAIL async_reset_addr: got %h expected 000", busS.rd_addr); end
        testsRun++; if (busS.whichRAM !== 1'b1 || busS.swap_ack !== 1'b0 || sFs !== 1'b0) begin testsFailed++; $display("FAIL async_reset_ctrl: got %b%b%b expected 100", busS.whichRAM, busS.swap_ack, sFs); end
        repeat (2) @(negedge clk);
        rstS_n = 1'b1;
        pos = 0;
        step_to(17);
        testsRun++; if (busS.rd_addr !== 12'd1) begin testsFailed++; $display("FAIL restart_addr: got %0d expected 1", busS.rd_addr); end
        step_to(18);
        testsRun++; if ({sR, sG, sB} !== expGrid || sBlank !== 1'b1) begin testsFailed++; $display("FAIL restart_pix_16_0: got %h expected %h", {sR, sG, sB}, expGrid); end
        step_to(53);
        testsRun++; if (sHs !== 1'b1) begin testsFailed++; $display("FAIL restart_hs_before: got %b expected 1", sHs); end
        step_to(54);
        testsRun++; if (sHs !== 1'b0) begin testsFailed++; $display("FAIL restart_hs_low: got %b expected 0", sHs); end
    endtask

    initial begin
        rstF_n = 1'b0;
        rstS_n = 1'b0;
        busF.swap_req = 1'b0;
        busS.swap_req = 1'b0;
        ramPatternS = 1'b0;
        testsRun = 0;
        testsFailed = 0;
        pos = 0;
        lastFs = 0;
        test_reset();
        test_line_timing();
        test_frame();
        test_swap_mid();
        test_swap_exact();
        test_back_to_back();
        test_address();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
